// File: rtl/fwrisc_dbus_pkg.sv
// Shared types and constants for the data-bus RAM responder.
// Strobe encodings match the byte-lane enables the core drives on dstrb.
package fwrisc_dbus_pkg;

    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] STRB_B0      = 4'b0001;
    localparam logic [3:0] STRB_B1      = 4'b0010;
    localparam logic [3:0] STRB_B2      = 4'b0100;
    localparam logic [3:0] STRB_B3      = 4'b1000;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    typedef struct packed {
        logic        write;
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

endpackage

// File: rtl/fwrisc_byte_en_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// One-cycle read latency; no flow control, no reset (contents survive reset).
module fwrisc_byte_en_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/fwrisc_dbus_ram_resp.sv
// Data-bus responder: captures one request in IDLE, completes it with a one-cycle dready
// WAIT_STATES+1 cycles later; inputs are ignored until back in IDLE (min 2 cycles/access).
module fwrisc_dbus_ram_resp
    import fwrisc_dbus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        dvalid,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    output logic        dready,
    output logic [31:0] drdata,
    output logic        derr
);

    localparam int   AW        = $clog2(DEPTH_WORDS);
    localparam cnt_t WAIT_INIT = cnt_t'(WAIT_STATES);

    state_t      state_q, state_d;
    cnt_t        cnt_q;
    req_t        req_q, live_req, cur_req;
    logic        in_range_q, cur_in_range, rng;
    logic        capture, enter_resp;
    logic        rd_zero_q;
    logic [29:0] woff;
    logic [31:0] ram_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^daddr[1:0];

    assign live_req = '{write: dwrite, waddr: daddr[31:2], wdata: dwdata, strb: dstrb};

    // With zero wait states the RAM edge is the capture edge, so the live request
    // feeds the RAM in IDLE; otherwise only the latched copy is used.
    assign cur_req      = (state_q == S_IDLE) ? live_req : req_q;
    assign woff         = cur_req.waddr - BASE_ADDR[31:2];
    assign cur_in_range = (woff[29:AW] == '0);
    assign rng          = (state_q == S_IDLE) ? cur_in_range : in_range_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dvalid) begin
                    capture = 1'b1;
                    if (WAIT_INIT == '0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == cnt_t'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            req_q      <= '0;
            in_range_q <= 1'b0;
        end else begin
            if (capture) begin
                cnt_q      <= WAIT_INIT;
                req_q      <= live_req;
                in_range_q <= cur_in_range;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - cnt_t'(1);
            end
        end
    end

    // The RAM read register has no reset, so a flag forces drdata to zero after
    // reset and after an out-of-range load until the next good load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         rd_zero_q <= 1'b1;
        else if (enter_resp && !cur_req.write) rd_zero_q <= !rng;
    end

    fwrisc_byte_en_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clock(clock),
        .we   (enter_resp && cur_req.write && rng),
        .be   (cur_req.strb),
        .re   (enter_resp && !cur_req.write && rng),
        .addr (woff[AW-1:0]),
        .wdata(cur_req.wdata),
        .rdata(ram_q)
    );

    assign dready = (state_q == S_RESP);
    assign derr   = dready && !in_range_q;
    assign drdata = rd_zero_q ? 32'h0 : ram_q;

endmodule
